pulse_count_display: RTL and testbench

PULSE_COUNT_DISPLAY -- requirements
Module: pulse_count_display

---
 rtl/pulse_count_display_pkg.sv | 25 ++
 rtl/pulse_count_display_hex_to_7seg.sv | 11 +
 rtl/pulse_count_display.sv | 101 ++++++++++
 tb/tb_pulse_count_display.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_count_display_pkg.sv
// Shared constants for the pulse counter and its multiplexed hex display.
// Segment order is {g,f,e,d,c,b,a}; all display signals are active-low.
package pulse_count_display_pkg;

    localparam int unsigned COUNT_W = 16;
    localparam int unsigned AN_W    = 4;
    localparam int unsigned SEG_W   = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;
    localparam logic [AN_W-1:0]  AN_OFF  = 4'b1111;

    // Hex glyphs indexed by nibble value, entry 15 first
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    // Active-low anode vector with only digit idx enabled
    function automatic logic [AN_W-1:0] an_for_digit(input logic [1:0] idx);
        return AN_OFF ^ (4'b0001 << idx);
    endfunction

endpackage

// File: rtl/pulse_count_display_hex_to_7seg.sv
// Combinational nibble-to-glyph decoder for an active-low seven-segment digit.
module hex_to_7seg
    import pulse_count_display_pkg::*;
(
    input  logic [3:0]       hex,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = SEG_TABLE[hex];

endmodule

// File: rtl/pulse_count_display.sv
// Up/down/clear pulse counter with a four-digit multiplexed hex display of the
// live count; requests act on their rising edge with no added latency.
module pulse_count_display
    import pulse_count_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               inc_pulse,
    input  logic               dec_pulse,
    input  logic               clr_pulse,
    output logic [COUNT_W-1:0] count,
    output logic               wrap,
    output logic [AN_W-1:0]    an,
    output logic [SEG_W-1:0]   seg,
    output logic               dp
);

    localparam int unsigned        DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    // Request bit positions within the history/detect vectors
    localparam int unsigned REQ_INC = 0;
    localparam int unsigned REQ_DEC = 1;
    localparam int unsigned REQ_CLR = 2;

    logic [2:0]         req_hist_q, req_hist_d;
    logic [2:0]         req_det_c;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               wrap_q, wrap_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         digit_q, digit_d;
    logic [AN_W-1:0]    an_q, an_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic               tick_c;
    logic [3:0]         nibble_c;
    logic [SEG_W-1:0]   glyph_c;

    // Edge detection and counter update; the result lands on the detecting edge
    always_comb begin
        req_hist_d = {clr_pulse, dec_pulse, inc_pulse};
        req_det_c  = req_hist_d & ~req_hist_q;
        count_d    = count_q;
        wrap_d     = 1'b0;
        if (req_det_c[REQ_CLR]) begin
            count_d = '0;
        end else if (req_det_c[REQ_INC] && !req_det_c[REQ_DEC]) begin
            count_d = count_q + 16'd1;
            wrap_d  = (count_q == 16'hFFFF);
        end else if (req_det_c[REQ_DEC] && !req_det_c[REQ_INC]) begin
            count_d = count_q - 16'd1;
            wrap_d  = (count_q == 16'h0000);
        end
    end

    // Refresh divider and digit scanner
    always_comb begin
        tick_c  = (div_q == DIV_LAST);
        div_d   = tick_c ? '0 : div_q + DIV_W'(1);
        digit_d = tick_c ? digit_q + 2'd1 : digit_q;
        an_d    = an_for_digit(digit_d);
    end

    // Glyph is derived from next-state values so anode and segments move together
    assign nibble_c = 4'(count_d >> {digit_d, 2'b00});

    hex_to_7seg u_hex_to_7seg (
        .hex   (nibble_c),
        .seg_c (glyph_c)
    );

    assign seg_d = glyph_c;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            req_hist_q <= '0;
            count_q    <= '0;
            wrap_q     <= 1'b0;
            div_q      <= '0;
            digit_q    <= '0;
            an_q       <= an_for_digit(2'd0);
            seg_q      <= SEG_TABLE[0];
        end else begin
            req_hist_q <= req_hist_d;
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            div_q      <= div_d;
            digit_q    <= digit_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = 1'b1;

endmodule

// File: tb/tb_pulse_count_display.sv
// Randomized self-checking bench for pulse_count_display against a cycle-level
// behavioural model of the counter and display scan.
module tb_pulse_count_display;

    localparam int unsigned DIV = 4;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        inc_pulse, dec_pulse, clr_pulse;
    logic [15:0] count;
    logic        wrap;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [28:0] obs;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int unsigned m_count;
    bit          m_wrap;
    bit          p_inc, p_dec, p_clr;
    int unsigned m_edges;

    localparam logic [28:0] RESET_OUT = {16'h0000, 1'b0, 4'b1110, 7'b1000000, 1'b1};

    pulse_count_display #(.REFRESH_DIV(DIV)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .inc_pulse (inc_pulse),
        .dec_pulse (dec_pulse),
        .clr_pulse (clr_pulse),
        .count     (count),
        .wrap      (wrap),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk_in = ~clk_in;

    assign obs = {count, wrap, an, seg, dp};

    function automatic logic [6:0] hex_seg(input int unsigned v);
        case (v)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            15: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected {count, wrap, an, seg, dp} from the model
    function automatic logic [28:0] exp_out();
        int unsigned digit;
        logic [3:0]  an_v;
        digit       = (m_edges / DIV) % 4;
        an_v        = 4'b1111;
        an_v[digit] = 1'b0;
        return {16'(m_count), m_wrap, an_v, hex_seg((m_count >> (4 * digit)) % 16), 1'b1};
    endfunction

    task automatic model_reset();
        m_count = 0; m_wrap = 0; m_edges = 0;
        p_inc = 0; p_dec = 0; p_clr = 0;
    endtask

    task automatic model_edge();
        bit ri, rd, rc;
        ri = inc_pulse && !p_inc;
        rd = dec_pulse && !p_dec;
        rc = clr_pulse && !p_clr;
        m_wrap = 0;
        if (rc) begin
            m_count = 0;
        end else if (ri && !rd) begin
            m_wrap  = (m_count == 65535);
            m_count = (m_count + 1) % 65536;
        end else if (rd && !ri) begin
            m_wrap  = (m_count == 0);
            m_count = (m_count + 65535) % 65536;
        end
        p_inc = inc_pulse; p_dec = dec_pulse; p_clr = clr_pulse;
        m_edges++;
    endtask

    // One clock: drive inputs, take the edge, settle
    task automatic cycle(input bit i, input bit d, input bit c);
        inc_pulse = i; dec_pulse = d; clr_pulse = c;
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; inc_pulse = 0; dec_pulse = 0; clr_pulse = 0;
        #3;
        checks++;
        if (obs !== RESET_OUT) begin
            failures++;
            $display("FAIL reset_async obs=%h expected=%h", obs, RESET_OUT);
        end
        @(posedge clk_in); #1;
        checks++;
        if (obs !== RESET_OUT) begin
            failures++;
            $display("FAIL reset_held obs=%h expected=%h", obs, RESET_OUT);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_three_inc();
        repeat (3) begin
            cycle(1, 0, 0);
            cycle(0, 0, 0);
        end
        checks++;
        if (count !== 16'd3) begin
            failures++;
            $display("FAIL three_inc_count count=%h expected=0003", count);
        end
        for (int k = 0; k < 16; k++) begin
            cycle(0, 0, 0);
            checks++;
            if (obs !== exp_out()) begin
                failures++;
                $display("FAIL three_inc_scan cyc=%0d obs=%h expected=%h", k, obs, exp_out());
            end
            if (an === 4'b1110) begin
                checks++;
                if (seg !== 7'b0110000) begin
                    failures++;
                    $display("FAIL three_inc_digit0 seg=%b expected=0110000", seg);
                end
            end
        end
    endtask

    task automatic test_wrap();
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        checks++;
        if ({count, wrap} !== {16'hFFFF, 1'b1} || obs !== exp_out()) begin
            failures++;
            $display("FAIL wrap_down count=%h wrap=%b expected=ffff/1", count, wrap);
        end
        cycle(0, 0, 0);
        checks++;
        if ({count, wrap} !== {16'hFFFF, 1'b0}) begin
            failures++;
            $display("FAIL wrap_down_clear count=%h wrap=%b expected=ffff/0", count, wrap);
        end
        cycle(1, 0, 0);
        checks++;
        if ({count, wrap} !== {16'h0000, 1'b1} || obs !== exp_out()) begin
            failures++;
            $display("FAIL wrap_up count=%h wrap=%b expected=0000/1", count, wrap);
        end
        cycle(0, 0, 0);
        checks++;
        if ({count, wrap} !== {16'h0000, 1'b0}) begin
            failures++;
            $display("FAIL wrap_up_clear count=%h wrap=%b expected=0000/0", count, wrap);
        end
    endtask

    task automatic test_held_inc();
        int unsigned base;
        base = m_count;
        for (int k = 0; k < 10; k++) begin
            cycle(1, 0, 0);
            checks++;
            if (obs !== exp_out()) begin
                failures++;
                $display("FAIL held_inc cyc=%0d obs=%h expected=%h", k, obs, exp_out());
            end
        end
        checks++;
        if (count !== 16'(base + 1)) begin
            failures++;
            $display("FAIL held_inc_total count=%h expected=%h", count, 16'(base + 1));
        end
        cycle(0, 0, 0);
    endtask

    task automatic test_simultaneous();
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        repeat (5) begin
            cycle(1, 0, 0);
            cycle(0, 0, 0);
        end
        cycle(1, 1, 0);
        checks++;
        if ({count, wrap} !== {16'd5, 1'b0} || obs !== exp_out()) begin
            failures++;
            $display("FAIL inc_dec_same count=%h wrap=%b expected=0005/0", count, wrap);
        end
        cycle(0, 0, 0);
        cycle(1, 0, 1);
        checks++;
        if ({count, wrap} !== {16'd0, 1'b0} || obs !== exp_out()) begin
            failures++;
            $display("FAIL inc_clr_same count=%h wrap=%b expected=0000/0", count, wrap);
        end
        cycle(0, 0, 0);
    endtask

    task automatic test_hex_display();
        logic [3:0] seen;
        logic [6:0] want;
        int         n;
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        n = 0;
        while (m_count != 16'hA5C3 && n < 70000) begin
            cycle(0, 1, 0);
            cycle(0, 0, 0);
            n++;
        end
        checks++;
        if (count !== 16'hA5C3) begin
            failures++;
            $display("FAIL hex_load count=%h expected=a5c3 after %0d decrements", count, n);
        end
        seen = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            cycle(0, 0, 0);
            case (an)
                4'b1110: begin want = 7'b0110000; seen[0] = 1'b1; end
                4'b1101: begin want = 7'b1000110; seen[1] = 1'b1; end
                4'b1011: begin want = 7'b0010010; seen[2] = 1'b1; end
                4'b0111: begin want = 7'b0001000; seen[3] = 1'b1; end
                default: want = 7'bxxxxxxx;
            endcase
            checks++;
            if (seg !== want || obs !== exp_out()) begin
                failures++;
                $display("FAIL hex_digit an=%b seg=%b expected seg=%b model=%h", an, seg, want, exp_out());
            end
        end
        checks++;
        if (seen !== 4'b1111) begin
            failures++;
            $display("FAIL hex_all_digits seen=%b expected=1111", seen);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0);
            checks++;
            if (obs !== exp_out()) begin
                failures++;
                $display("FAIL random cyc=%0d obs=%h expected=%h", k, obs, exp_out());
            end
        end
        cycle(0, 0, 0);
    endtask

    task automatic test_async_reset();
        int n;
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        repeat (7) begin
            cycle(1, 0, 0);
            cycle(0, 0, 0);
        end
        n = 0;
        while (((m_edges / DIV) % 4) != 2 && n < 32) begin
            cycle(0, 0, 0);
            n++;
        end
        checks++;
        if (count !== 16'd7 || an !== 4'b1011) begin
            failures++;
            $display("FAIL async_setup count=%h an=%b expected=0007/1011", count, an);
        end
        #2;
        reset = 1'b1;
        inc_pulse = 1'b1;
        #1;
        checks++;
        if (obs !== RESET_OUT) begin
            failures++;
            $display("FAIL async_reset obs=%h expected=%h", obs, RESET_OUT);
        end
        @(posedge clk_in); #1;
        reset = 1'b0;
        model_reset();
        cycle(1, 0, 0);
        checks++;
        if (count !== 16'd1 || obs !== exp_out()) begin
            failures++;
            $display("FAIL held_through_reset count=%h expected=0001", count);
        end
        cycle(1, 0, 0);
        checks++;
        if (count !== 16'd1 || obs !== exp_out()) begin
            failures++;
            $display("FAIL held_after_reset count=%h expected=0001", count);
        end
        cycle(0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_three_inc();
        test_wrap();
        test_held_inc();
        test_simultaneous();
        test_random();
        test_hex_display();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
